// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, line levels, FSM states and parity helper.
// Used by both the transmitter and the receiver on the same bus.
package uart_pkg;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Parity bit that makes {parity, data} contain an odd number of ones.
   function automatic logic odd_parity(input logic [DATA_BITS-1:0] data_byte);
      return ~^data_byte;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host-side source (master) and the UART transmitter (slave).
interface uart_tx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last count.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 80
) (
   input  logic uart_clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge uart_clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear || bit_end)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign bit_end = !clear && (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, odd parity, stop.
// Define UART_TX_HOLD_EN to add a one-byte holding register for gapless back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 80
) (
   input  logic        uart_clk,
   input  logic        reset,
   uart_tx_if.slave    host,
   output logic        tx_line,
   output logic        tx_oe,
   output logic        busy,
   output logic        done
);

   uart_state_t          state, state_n;
   logic [DATA_BITS-1:0] shift_reg, shift_n;
   logic                 parity_bit, parity_n;
   logic [2:0]           bit_idx, bit_idx_n;
   logic                 done_n;
   logic                 bit_end;
   logic                 handshake;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .uart_clk (uart_clk),
      .reset    (reset),
      .clear    (state == IDLE),
      .bit_end  (bit_end)
   );

`ifdef UART_TX_HOLD_EN
   logic [DATA_BITS-1:0] hold_data, hold_data_n;
   logic                 hold_parity, hold_parity_n;
   logic                 hold_full, hold_full_n;

   assign host.tx_ready = reset && !hold_full;
`else
   assign host.tx_ready = reset && (state == IDLE);
`endif

   assign handshake = host.tx_valid && host.tx_ready;

   always_ff @(posedge uart_clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         parity_bit  <= 1'b0;
         bit_idx     <= '0;
         done        <= 1'b0;
`ifdef UART_TX_HOLD_EN
         hold_data   <= '0;
         hold_parity <= 1'b0;
         hold_full   <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         shift_reg   <= shift_n;
         parity_bit  <= parity_n;
         bit_idx     <= bit_idx_n;
         done        <= done_n;
`ifdef UART_TX_HOLD_EN
         hold_data   <= hold_data_n;
         hold_parity <= hold_parity_n;
         hold_full   <= hold_full_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      shift_n   = shift_reg;
      parity_n  = parity_bit;
      bit_idx_n = bit_idx;
      done_n    = 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_data_n   = hold_data;
      hold_parity_n = hold_parity;
      hold_full_n   = hold_full;
`endif

      unique case (state)
         IDLE: begin
            if (handshake) begin
               shift_n   = host.tx_data;
               parity_n  = odd_parity(host.tx_data);
               bit_idx_n = '0;
               state_n   = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_n   = shift_reg >> 1;
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_n = PARITY;
            end
         end
         PARITY: begin
            if (bit_end)
               state_n = STOP;
         end
         STOP: begin
            if (bit_end) begin
               done_n  = 1'b1;
               state_n = IDLE;
`ifdef UART_TX_HOLD_EN
               // A queued byte starts its start bit right after this stop bit.
               if (hold_full) begin
                  shift_n     = hold_data;
                  parity_n    = hold_parity;
                  bit_idx_n   = '0;
                  hold_full_n = 1'b0;
                  state_n     = START;
               end
`endif
            end
         end
         default: state_n = IDLE;
      endcase

`ifdef UART_TX_HOLD_EN
      if (handshake && (state != IDLE)) begin
         hold_data_n   = host.tx_data;
         hold_parity_n = odd_parity(host.tx_data);
         hold_full_n   = 1'b1;
      end
`endif
   end

   always_comb begin
      tx_line = STOP_LEVEL;
      unique case (state)
         IDLE:    tx_line = 1'b1;
         START:   tx_line = START_LEVEL;
         DATA:    tx_line = shift_reg[0];
         PARITY:  tx_line = parity_bit;
         STOP:    tx_line = STOP_LEVEL;
         default: tx_line = 1'b1;
      endcase
   end

   assign tx_oe = (state != IDLE);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a CLKS_PER_BIT=8 instance and a CLKS_PER_BIT=2 corner instance.
module tb_uart_tx;

   logic uart_clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   uart_tx_if ifa ();
   uart_tx_if ifb ();
   logic line_a, oe_a, busy_a, done_a;
   logic line_b, oe_b, busy_b, done_b;

   uart_tx #(.CLKS_PER_BIT(8)) dut_a (
      .uart_clk (uart_clk),
      .reset    (reset),
      .host     (ifa.slave),
      .tx_line  (line_a),
      .tx_oe    (oe_a),
      .busy     (busy_a),
      .done     (done_a)
   );

   uart_tx #(.CLKS_PER_BIT(2)) dut_b (
      .uart_clk (uart_clk),
      .reset    (reset),
      .host     (ifb.slave),
      .tx_line  (line_b),
      .tx_oe    (oe_b),
      .busy     (busy_b),
      .done     (done_b)
   );

   initial forever #5 uart_clk = ~uart_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observed {tx_line, tx_oe, busy, done} of the selected instance.
   function automatic logic [3:0] obs(input bit sel);
      return sel ? {line_b, oe_b, busy_b, done_b} : {line_a, oe_a, busy_a, done_a};
   endfunction

   function automatic logic ready(input bit sel);
      return sel ? ifb.tx_ready : ifa.tx_ready;
   endfunction

   task automatic set_data(input bit sel, input logic [7:0] d);
      if (sel) ifb.tx_data = d; else ifa.tx_data = d;
   endtask

   task automatic set_valid(input bit sel, input logic v);
      if (sel) ifb.tx_valid = v; else ifa.tx_valid = v;
   endtask

   // Called at the negedge of the first start-bit cycle; returns at the negedge after the stop bit.
   task automatic check_frame(input bit sel, input logic [7:0] b, input logic first_done,
                              input int drop_at, input int pulse_at);
      int          cpb;
      logic [10:0] frame;
      logic [10:0] rx;
      logic [3:0]  exp;
      cpb   = sel ? 2 : 8;
      frame = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
      rx    = '0;
      for (int i = 0; i < 11 * cpb; i++) begin
         if (i == pulse_at) begin
            set_data(sel, ~b);
            set_valid(sel, 1'b1);
         end
         if (i == drop_at)
            set_valid(sel, 1'b0);
         exp = {frame[i / cpb], 1'b1, 1'b1, (i == 0) ? first_done : 1'b0};
         check($sformatf("frame%0d_%02h_cyc%0d", sel, b, i), {28'd0, obs(sel)}, {28'd0, exp});
`ifndef UART_TX_HOLD_EN
         check($sformatf("ready_busy%0d_cyc%0d", sel, i), {31'd0, ready(sel)}, 32'd0);
`endif
         if (i % cpb == cpb / 2)
            rx[i / cpb] = obs(sel)[3];
         @(negedge uart_clk);
      end
      check($sformatf("rx_data%0d", sel), {24'd0, rx[8:1]}, {24'd0, b});
      check($sformatf("rx_parity_odd%0d", sel), {31'd0, ^rx[9:1]}, 32'd1);
      check($sformatf("rx_start_stop%0d", sel), {30'd0, rx[10], rx[0]}, 32'd2);
   endtask

   task automatic post_frame(input bit sel);
      check($sformatf("post_frame%0d", sel), {28'd0, obs(sel)}, 32'h9);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b);
      check($sformatf("ready_idle%0d", sel), {31'd0, ready(sel)}, 32'd1);
      set_data(sel, b);
      set_valid(sel, 1'b1);
      @(negedge uart_clk);
      set_valid(sel, 1'b0);
      check_frame(sel, b, 1'b0, -1, -1);
      post_frame(sel);
      @(negedge uart_clk);
      check($sformatf("idle_after%0d", sel), {28'd0, obs(sel)}, 32'h8);
   endtask

   initial begin
      logic [7:0] rnd;
      reset        = 1'b0;
      ifa.tx_data  = 8'h00;
      ifa.tx_valid = 1'b0;
      ifb.tx_data  = 8'h00;
      ifb.tx_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge uart_clk);
      check("reset_outputs", {28'd0, obs(0)}, 32'h8);
      check("reset_ready", {31'd0, ready(0)}, 32'd0);
      check("reset_outputs_b", {28'd0, obs(1)}, 32'h8);
      reset = 1'b1;
      @(negedge uart_clk);
      check("ready_after_reset", {31'd0, ready(0)}, 32'd1);

      // Directed frames and parity corners
      send_frame(0, 8'hA5);
      send_frame(0, 8'h00);
      send_frame(0, 8'h01);

      // Randomized bytes
      for (int k = 0; k < 5; k++) begin
         rnd = 8'($urandom_range(0, 255));
         send_frame(0, rnd);
      end

      // tx_valid held high across two frames
      set_data(0, 8'h3C);
      set_valid(0, 1'b1);
      @(negedge uart_clk);
      set_data(0, 8'hC3);
`ifdef UART_TX_HOLD_EN
      check_frame(0, 8'h3C, 1'b0, 1, -1);
      check_frame(0, 8'hC3, 1'b1, -1, -1);
`else
      check_frame(0, 8'h3C, 1'b0, -1, -1);
      post_frame(0);
      check("ready_gap", {31'd0, ready(0)}, 32'd1);
      @(negedge uart_clk);
      set_valid(0, 1'b0);
      check_frame(0, 8'hC3, 1'b0, -1, -1);
`endif
      post_frame(0);
      @(negedge uart_clk);
      check("idle_after_pair", {28'd0, obs(0)}, 32'h8);

      // Reset in the middle of data bit 4
      set_data(0, 8'hF0);
      set_valid(0, 1'b1);
      @(negedge uart_clk);
      set_valid(0, 1'b0);
      repeat (42) @(negedge uart_clk);
      check("pre_abort_busy", {31'd0, busy_a}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_outputs", {28'd0, obs(0)}, 32'h8);
      check("abort_ready", {31'd0, ready(0)}, 32'd0);
      @(negedge uart_clk);
      reset = 1'b1;
      @(negedge uart_clk);
      check("abort_idle", {28'd0, obs(0)}, 32'h8);
      send_frame(0, 8'h5A);

`ifndef UART_TX_HOLD_EN
      // tx_valid pulsed mid-frame must be ignored
      set_data(0, 8'h96);
      set_valid(0, 1'b1);
      @(negedge uart_clk);
      set_valid(0, 1'b0);
      check_frame(0, 8'h96, 1'b0, 23, 20);
      post_frame(0);
      set_valid(0, 1'b0);
      repeat (3) @(negedge uart_clk);
      check("no_spurious_frame", {28'd0, obs(0)}, 32'h8);
`endif

      // CLKS_PER_BIT=2 corner
      send_frame(1, 8'h6B);
      for (int k = 0; k < 3; k++) begin
         rnd = 8'($urandom_range(0, 255));
         send_frame(1, rnd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter for the team's UART link. Takes a byte over a valid/ready handshake and drives one frame onto the shared UART bus. Frame: start bit (0), 8 data bits LSB first, odd-parity bit, stop bit (1). The frame format matches the existing receiver, so a receiver on the same bus accepts every frame without error. Sits between the host-side byte source and the bidirectional bus pad; the pad combines tx_line with tx_oe.

Parameters:
CLKS_PER_BIT, 80, uart_clk cycles per serial bit; must be >= 2; bit counter width is $clog2(CLKS_PER_BIT)

Ports:
uart_clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
tx_data  input  8  byte to send; sampled only on the handshake cycle
tx_valid  input  1  source has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx_line  output  1  serial output; 1 when idle
tx_oe  output  1  bus drive enable; 1 only while a frame is on the line
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Reset (async, reset=0): state=IDLE, tx_line=1, tx_oe=0, tx_ready=0 while reset is asserted, busy=0, done=0, all counters and shift register = 0. A mid-frame reset aborts the frame immediately; the line returns to 1 with no stop bit.
- tx_ready=1 in IDLE after reset releases. A transfer occurs on any rising edge with tx_valid && tx_ready.
- On transfer: latch tx_data into an 8-bit shift register and latch parity = ~^tx_data, so the 9 bits {parity,data} have odd parity. Next state is START. tx_line goes 0 on the cycle after the handshake (latency 1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state holds for exactly CLKS_PER_BIT cycles. The clock counter runs 0..CLKS_PER_BIT-1, then wraps to 0.
  - START: tx_line=0; on wrap, go to DATA with bit index 0.
  - DATA: tx_line = shift_reg[0]; on wrap, shift right and increment the index. After index 7 wraps, go to PARITY.
  - PARITY: tx_line = parity bit; on wrap, go to STOP.
  - STOP: tx_line=1; on wrap, done=1 for one cycle and go to IDLE.
- Full frame is 11*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- tx_oe=1 from the first START cycle through the last STOP cycle; 0 otherwise.
- tx_valid high in a non-ready cycle is ignored; tx_data is not sampled.
- tx_valid held high continuously: next handshake in IDLE one cycle after done. Line gap = 1 idle-high cycle.
- Bit index counter is 3 bits and never exceeds 7.

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- Defined:
  - Adds a one-entry holding register (data + parity + full flag). tx_ready = !hold_full, so a byte can be accepted mid-frame.
  - At STOP wrap with hold_full=1: load the shift register from hold, clear hold_full, go directly to START. No idle cycle between frames; done still pulses. The stop bit stays full length.
  - Handshake in the same cycle as that load: the new byte goes into hold, and hold_full stays 1.
  - In IDLE, a handshake bypasses hold and goes straight to the shift register.
- Not defined: tx_ready = (state==IDLE), and behaviour is as above.

Decomposition:
- Package uart_pkg:
  - FSM state localparams/typedef shared with the receiver
  - DATA_BITS=8, FRAME_BITS=11, START_LEVEL=0, STOP_LEVEL=1
  - odd_parity(byte) function
- One sub-module, uart_bit_timer: counter 0..CLKS_PER_BIT-1 with clear input and bit_end output pulse. Reusable by the receiver.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 -> tx_line is 0 for 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), parity 1, stop 1. done pulses at cycle 88 after the first start cycle. tx_oe is high for exactly 88 cycles.
- Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0. A receiver instance on a loopback bus reports error=0 and data_out matching each byte.
- tx_valid held high with 0x3C then 0xC3 -> second handshake the cycle after done, and exactly one idle-high cycle between frames. With UART_TX_HOLD_EN: second byte accepted during the first frame, zero idle cycles, and two done pulses 88 cycles apart.
- Assert reset during DATA bit 4 -> same cycle tx_line=1, tx_oe=0, busy=0. After release, tx_ready=1 and a fresh 0x5A frame is correct.
- tx_valid pulsed while busy (no HOLD_EN) -> no handshake, no data corruption, and the current frame completes unchanged.
- CLKS_PER_BIT=2 corner -> frame is 22 cycles and bit boundaries are exact.
